// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit.
package ex_muldiv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PROD_W = 2 * XLEN;
    localparam int unsigned CNT_W  = $clog2(XLEN);

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_t;

    // Magnitude of a two's complement value when sgn is set; -2^(XLEN-1) maps to itself.
    function automatic logic [XLEN-1:0] md_abs(input logic [XLEN-1:0] x, input logic sgn);
        return sgn ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Pipeline-side bundle of the multiply/divide unit: ID/EX controls in, HI/LO and hazard signals out.
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    logic            Start;
    logic [1:0]      Op;
    logic [XLEN-1:0] OpA;
    logic [XLEN-1:0] OpB;
    logic            HiWr;
    logic            LoWr;
    logic [XLEN-1:0] WData;
    logic            HiLoRd;
    logic            Flush;
    logic            Busy;
    logic            Stall;
    logic            Done;
    logic            DivZero;
    logic [XLEN-1:0] Hi;
    logic [XLEN-1:0] Lo;

    modport master (
        output Start, Op, OpA, OpB, HiWr, LoWr, WData, HiLoRd, Flush,
        input  Busy, Stall, Done, DivZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, OpA, OpB, HiWr, LoWr, WData, HiLoRd, Flush,
        output Busy, Stall, Done, DivZero, Hi, Lo
    );

endinterface

// File: rtl/ex_muldiv_md_step.sv
// One iteration on {acc, q}: shift-add multiply step or restoring-divide step.
module md_step
    import ex_muldiv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] q_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
        shifted = {acc, q[XLEN-1]};
        diff    = shifted - {1'b0, b};
        acc_nxt = '0;
        q_nxt   = '0;
        if (is_div) begin
            // Partial remainder stays below b, so diff's top bit is a clean borrow flag.
            if (!diff[XLEN]) begin
                acc_nxt = diff[XLEN-1:0];
                q_nxt   = {q[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[XLEN-1:0];
                q_nxt   = {q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = sum[XLEN:1];
            q_nxt   = {sum[0], q[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  md
);

    md_state_t         state;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   b;
    logic [CNT_W-1:0]  count;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;

    logic [XLEN-1:0]   acc_nxt;
    logic [XLEN-1:0]   q_nxt;

    logic              op_signed;
    logic              op_div;
    logic              sgn_a;
    logic              sgn_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;

    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

    md_step u_step (
        .is_div  (is_div),
        .acc     (acc),
        .q       (q),
        .b       (b),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt)
    );

    // Operand decode for the op being accepted this cycle.
    always_comb begin
        op_signed = (md.Op == MD_MULT) || (md.Op == MD_DIV);
        op_div    = (md.Op == MD_DIV)  || (md.Op == MD_DIVU);
        sgn_a     = op_signed & md.OpA[XLEN-1];
        sgn_b     = op_signed & md.OpB[XLEN-1];
        abs_a     = md_abs(md.OpA, sgn_a);
        abs_b     = md_abs(md.OpB, sgn_b);
    end

    // Sign correction; on divide-by-zero acc holds |OpA|, so the dividend sign restores OpA.
    always_comb begin
        prod     = {acc, q};
        prod_fix = neg_q ? PROD_W'(-prod) : prod;
        rem_fix  = neg_r ? XLEN'(-acc) : acc;
        fix_hi   = prod_fix[PROD_W-1:XLEN];
        fix_lo   = prod_fix[XLEN-1:0];
        if (is_div) begin
            fix_hi = rem_fix;
            fix_lo = div_zero ? '1 : (neg_q ? XLEN'(-q) : q);
        end
    end

    assign md.Stall = md.Busy & (md.Start | md.HiLoRd | md.HiWr | md.LoWr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            q          <= '0;
            b          <= '0;
            count      <= '0;
            is_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
            md.Busy    <= 1'b0;
            md.Done    <= 1'b0;
            md.DivZero <= 1'b0;
            md.Hi      <= '0;
            md.Lo      <= '0;
        end else begin
            md.Done    <= 1'b0;
            md.DivZero <= 1'b0;
            if (md.Flush) begin
                // Aborted op: HI/LO untouched, no completion pulse.
                state   <= IDLE;
                md.Busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (md.HiWr) md.Hi <= md.WData;
                        if (md.LoWr) md.Lo <= md.WData;
                        if (md.Start) begin
                            state    <= CALC;
                            md.Busy  <= 1'b1;
                            count    <= '0;
                            acc      <= '0;
                            is_div   <= op_div;
                            neg_q    <= sgn_a ^ sgn_b;
                            neg_r    <= sgn_a;
                            div_zero <= op_div && (md.OpB == '0);
                            q        <= op_div ? abs_a : abs_b;
                            b        <= op_div ? abs_b : abs_a;
                        end
                    end
                    CALC: begin
                        acc   <= acc_nxt;
                        q     <= q_nxt;
                        count <= count + 1'b1;
                        if (count == CNT_W'(XLEN - 1)) state <= FIX;
                    end
                    FIX: begin
                        md.Hi      <= fix_hi;
                        md.Lo      <= fix_lo;
                        md.Done    <= 1'b1;
                        md.DivZero <= div_zero;
                        md.Busy    <= 1'b0;
                        state      <= IDLE;
                    end
                    default: begin
                        state   <= IDLE;
                        md.Busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, results, divide-by-zero, flush, stall and reset behaviour.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ex_muldiv_if io ();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst),
        .md  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents Start in cycle 0; returns 1 time unit into cycle 1.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        tick(1);
        io.Start = 1'b1;
        io.Op    = op;
        io.OpA   = a;
        io.OpB   = b;
        tick(1);
        io.Start = 1'b0;
    endtask

    // Full op with latency and result checks.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input logic dz);
        start_op(op, a, b);
        check({tag, " busy@1"}, 64'(io.Busy), 64'd1);
        tick(32);
        check({tag, " busy@33"}, 64'({io.Busy, io.Done}), 64'b10);
        tick(1);
        check({tag, " done@34"}, 64'({io.Busy, io.Done, io.DivZero}), 64'({2'b01, dz}));
        check({tag, " hi"}, 64'(io.Hi), 64'(hi));
        check({tag, " lo"}, 64'(io.Lo), 64'(lo));
        tick(1);
        check({tag, " done@35"}, 64'({io.Done, io.DivZero}), 64'd0);
    endtask

    initial begin
        logic done_seen;
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        io.Start  = 1'b0;
        io.Op     = MD_MULT;
        io.OpA    = '0;
        io.OpB    = '0;
        io.HiWr   = 1'b0;
        io.LoWr   = 1'b0;
        io.WData  = '0;
        io.HiLoRd = 1'b0;
        io.Flush  = 1'b0;
        tick(2);
        rst = 1'b0;
        check("reset flags", 64'({io.Busy, io.Stall, io.Done, io.DivZero}), 64'd0);
        check("reset hilo", {io.Hi, io.Lo}, 64'd0);

        run_op("mult -2x3",      MD_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu max",      MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult min*min",   MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("div -7/2",       MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu big",       MD_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
        run_op("div min/-1",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("div 5/0",        MD_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
        run_op("div -5/0",       MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run_op("divu 100/7",     MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);

        // MTLO, then MULT flushed at cycle 10.
        tick(1);
        io.LoWr  = 1'b1;
        io.WData = 32'h1234;
        tick(1);
        io.LoWr = 1'b0;
        check("mtlo", 64'(io.Lo), 64'h1234);
        start_op(MD_MULT, 32'd6, 32'd7);
        tick(9);
        io.Flush = 1'b1;
        tick(1);
        io.Flush = 1'b0;
        check("flush idle", 64'({io.Busy, io.Done}), 64'd0);
        check("flush lo", 64'(io.Lo), 64'h1234);
        check("flush hi", 64'(io.Hi), 64'd2);
        done_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            done_seen = done_seen | io.Done;
        end
        check("flush no done", 64'(done_seen), 64'd0);

        // Flush coinciding with FIX suppresses the write.
        start_op(MD_MULT, 32'd6, 32'd7);
        tick(32);
        io.Flush = 1'b1;
        tick(1);
        io.Flush = 1'b0;
        check("flush fix done", 64'({io.Busy, io.Done}), 64'd0);
        check("flush fix hilo", {io.Hi, io.Lo}, {32'd2, 32'h1234});

        // Start with Flush in IDLE does not begin an op.
        tick(1);
        io.Start = 1'b1;
        io.Flush = 1'b1;
        tick(1);
        io.Start = 1'b0;
        io.Flush = 1'b0;
        check("start+flush", 64'(io.Busy), 64'd0);

        // MTHI with Start: write lands, op still runs and overwrites at FIX.
        tick(1);
        io.Start = 1'b1;
        io.Op    = MD_MULTU;
        io.OpA   = 32'd6;
        io.OpB   = 32'd7;
        io.HiWr  = 1'b1;
        io.WData = 32'hABCD;
        tick(1);
        io.Start = 1'b0;
        io.HiWr  = 1'b0;
        check("mthi+start", 64'({io.Busy, io.Hi}), {31'd0, 1'b1, 32'hABCD});
        tick(33);
        check("mthi overwritten", {io.Hi, io.Lo}, {32'd0, 32'd42});

        // MFHI behind an in-flight op stalls until FIX; Start while busy is ignored.
        start_op(MD_MULTU, 32'd3, 32'd5);
        tick(4);
        io.HiLoRd = 1'b1;
        #1;
        check("stall mfhi@5", 64'(io.Stall), 64'd1);
        tick(1);
        io.Start = 1'b1;
        io.Op    = MD_DIVU;
        io.OpA   = 32'd9;
        io.OpB   = 32'd4;
        #1;
        check("stall start@6", 64'(io.Stall), 64'd1);
        tick(1);
        io.Start = 1'b0;
        tick(26);
        check("stall@33", 64'(io.Stall), 64'd1);
        tick(1);
        check("stall drop@34", 64'({io.Stall, io.Done}), 64'b01);
        check("ignored start", {io.Hi, io.Lo}, {32'd0, 32'd15});
        io.HiLoRd = 1'b0;

        // Reset mid-op clears everything.
        start_op(MD_MULT, 32'hFFFF_FFFF, 32'd9);
        tick(9);
        rst = 1'b1;
        tick(1);
        check("rst midop flags", 64'({io.Busy, io.Stall, io.Done, io.DivZero}), 64'd0);
        check("rst midop hilo", {io.Hi, io.Lo}, 64'd0);
        rst = 1'b0;
        tick(40);
        check("rst no done", 64'({io.Busy, io.Done}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
